// File: rtl/benes_perm_scheduler.sv
// Burst scheduler for a pipelined Benes network: stores per-stage switch configurations and
// drives each stage's switch_set in step with the beat occupying that stage.
module benes_perm_scheduler #(
   parameter int unsigned SWITCH_NUM = 16,
   parameter int unsigned STAGE_NUM  = 9,
   parameter int unsigned STAGE_LAT  = 2,
   parameter int unsigned OUT_LAT    = 17,
   parameter int unsigned NUM_CFG    = 4,
   parameter int unsigned CFG_W      = 2,
   parameter int unsigned LEN_W      = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cfg_we,
   output logic                                  cfg_ready,
   input  logic [CFG_W-1:0]                      cfg_id,
   input  logic [3:0]                            cfg_stage,
   input  logic [SWITCH_NUM-1:0]                 cfg_data,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [CFG_W-1:0]                      req_cfg_id,
   input  logic [LEN_W-1:0]                      req_len,
   output logic                                  net_in_valid,
   output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]  switch_set,
   output logic                                  out_valid,
   output logic                                  out_last,
   output logic                                  busy
);

   localparam int unsigned PIPE_D = OUT_LAT + 1;

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   typedef struct packed {
      logic             valid;
      logic [CFG_W-1:0] id;
      logic             last;
   } tag_t;

   state_e                                           state_q, state_d;
   logic [CFG_W-1:0]                                 cur_id_q, cur_id_d;
   logic [LEN_W-1:0]                                 rem_q, rem_d;
   tag_t [PIPE_D-1:0]                                pipe_q, pipe_d;
   logic [NUM_CFG-1:0][STAGE_NUM-1:0][SWITCH_NUM-1:0] cfg_tbl_q, cfg_tbl_d;
   logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]             sw_q, sw_d;
   logic                                             any_valid;
   logic                                             req_fire;

   always_comb begin
      any_valid = 1'b0;
      for (int k = 0; k < int'(PIPE_D); k++) begin
         any_valid = any_valid | pipe_q[k].valid;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_id_d  = cur_id_q;
      rem_d     = rem_q;
      // The final beat of a burst can accept the next request for a gapless handoff.
      req_ready = (state_q == StIdle) || (rem_q == LEN_W'(1));
      req_fire  = req_valid & req_ready;
      if (state_q == StIssue) begin
         rem_d = rem_q - LEN_W'(1);
         if (rem_q == LEN_W'(1)) begin
            state_d = StIdle;
         end
      end
      if (req_fire && (req_len != '0)) begin
         state_d  = StIssue;
         cur_id_d = req_cfg_id;
         rem_d    = req_len;
      end
   end

   // pipe_d[0] describes the beat entering the network next cycle; pipe_q[k] is k cycles old.
   always_comb begin
      pipe_d[0].valid = (state_d == StIssue);
      pipe_d[0].id    = cur_id_d;
      pipe_d[0].last  = (rem_d == LEN_W'(1));
      for (int k = 1; k < int'(PIPE_D); k++) begin
         pipe_d[k] = pipe_q[k-1];
      end
   end

   always_comb begin
      cfg_tbl_d = cfg_tbl_q;
      for (int s = 0; s < int'(STAGE_NUM); s++) begin
         if (cfg_we && cfg_ready && (cfg_stage == 4'(s))) begin
            cfg_tbl_d[cfg_id][s] = cfg_data;
         end
      end
   end

   // Each stage register loads only when a valid beat arrives there; otherwise it holds.
   always_comb begin
      sw_d = sw_q;
      for (int s = 0; s < int'(STAGE_NUM); s++) begin
         if (pipe_d[s*STAGE_LAT].valid) begin
            sw_d[s] = cfg_tbl_q[pipe_d[s*STAGE_LAT].id][s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cur_id_q  <= '0;
         rem_q     <= '0;
         pipe_q    <= '0;
         cfg_tbl_q <= '0;
         sw_q      <= '0;
      end else begin
         state_q   <= state_d;
         cur_id_q  <= cur_id_d;
         rem_q     <= rem_d;
         pipe_q    <= pipe_d;
         cfg_tbl_q <= cfg_tbl_d;
         sw_q      <= sw_d;
      end
   end

   assign busy         = (state_q == StIssue) | any_valid;
   assign cfg_ready    = (state_q == StIdle) & ~busy;
   assign net_in_valid = (state_q == StIssue);
   assign switch_set   = sw_q;
   assign out_valid    = pipe_q[OUT_LAT].valid;
   assign out_last     = pipe_q[OUT_LAT].valid & pipe_q[OUT_LAT].last;

endmodule

// File: tb/tb_benes_perm_scheduler.sv
// Randomized bench for benes_perm_scheduler against a cycle-indexed expectation schedule
// built from the burst timing rules (beat at T, stage s at T+2s, output at T+17).
module tb_benes_perm_scheduler;

   localparam int MAXC = 4096;
   localparam int NST  = 9;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 cfg_we = 1'b0;
   logic                 cfg_ready;
   logic [1:0]           cfg_id = '0;
   logic [3:0]           cfg_stage = '0;
   logic [15:0]          cfg_data = '0;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [1:0]           req_cfg_id = '0;
   logic [7:0]           req_len = '0;
   logic                 net_in_valid;
   logic [8:0][15:0]     switch_set;
   logic                 out_valid;
   logic                 out_last;
   logic                 busy;

   benes_perm_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_ready    (cfg_ready),
      .cfg_id       (cfg_id),
      .cfg_stage    (cfg_stage),
      .cfg_data     (cfg_data),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cfg_id   (req_cfg_id),
      .req_len      (req_len),
      .net_in_valid (net_in_valid),
      .switch_set   (switch_set),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Stimulus shadows, applied on the falling edge.
   bit          s_rst = 1'b1;
   bit          s_cfg_we;
   int          s_cfg_id;
   int          s_cfg_stage;
   logic [15:0] s_cfg_data;
   bit          s_req_valid;
   int          s_req_id;
   int          s_req_len;

   // Expectation schedule indexed by absolute cycle.
   bit          e_niv  [MAXC];
   bit          e_ov   [MAXC];
   bit          e_ol   [MAXC];
   bit          e_busy [MAXC];
   bit          swm    [MAXC][NST];
   logic [15:0] swv    [MAXC][NST];
   logic [15:0] mtbl   [4][NST];
   logic [15:0] msw    [NST];
   int          issue_end = 0;
   int          cyc = 0;
   int          chk_start = 3;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [143:0] got, input logic [143:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit m_req_ready(input int c);
      return (c >= issue_end) || (c == issue_end - 1);
   endfunction

   task automatic check_cycle();
      logic [8:0][15:0] exp_sw;
      for (int s = 0; s < NST; s++) begin
         if (swm[cyc][s]) msw[s] = swv[cyc][s];
         exp_sw[s] = msw[s];
      end
      if (cyc < chk_start) return;
      check_val("req_ready", 144'(req_ready), 144'(m_req_ready(cyc)));
      check_val("cfg_ready", 144'(cfg_ready), 144'((cyc >= issue_end) && !e_busy[cyc]));
      check_val("net_in_valid", 144'(net_in_valid), 144'(e_niv[cyc]));
      check_val("out_valid", 144'(out_valid), 144'(e_ov[cyc]));
      check_val("out_last", 144'(out_last), 144'(e_ol[cyc]));
      check_val("busy", 144'(busy), 144'(e_busy[cyc]));
      check_val("switch_set", 144'(switch_set), 144'(exp_sw));
   endtask

   task automatic model_edge(input int c);
      bit rdy;
      if (s_rst) begin
         for (int k = c + 1; k < MAXC; k++) begin
            e_niv[k] = 0; e_ov[k] = 0; e_ol[k] = 0; e_busy[k] = 0;
            for (int s = 0; s < NST; s++) swm[k][s] = 0;
         end
         for (int i = 0; i < 4; i++) for (int s = 0; s < NST; s++) mtbl[i][s] = '0;
         for (int s = 0; s < NST; s++) msw[s] = '0;
         issue_end = c + 1;
         return;
      end
      rdy = m_req_ready(c);
      if (s_cfg_we && (c >= issue_end) && !e_busy[c] && s_cfg_stage < NST)
         mtbl[s_cfg_id][s_cfg_stage] = s_cfg_data;
      if (s_req_valid && rdy && s_req_len > 0) begin
         for (int i = 0; i < s_req_len; i++) begin
            int t;
            t = c + 1 + i;
            e_niv[t] = 1;
            for (int s = 0; s < NST; s++) begin
               swm[t + 2*s][s] = 1;
               swv[t + 2*s][s] = mtbl[s_req_id][s];
            end
            e_ov[t + 17] = 1;
            e_ol[t + 17] = (i == s_req_len - 1);
            for (int k = t; k <= t + 17; k++) e_busy[k] = 1;
         end
         issue_end = c + 1 + s_req_len;
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      rst        = s_rst;
      cfg_we     = s_cfg_we;
      cfg_id     = 2'(s_cfg_id);
      cfg_stage  = 4'(s_cfg_stage);
      cfg_data   = s_cfg_data;
      req_valid  = s_req_valid;
      req_cfg_id = 2'(s_req_id);
      req_len    = 8'(s_req_len);
      model_edge(cyc);
      @(posedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      s_rst = 0; s_cfg_we = 0; s_req_valid = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic cfg_write(input int id, input int st, input logic [15:0] d);
      s_cfg_we = 1; s_cfg_id = id; s_cfg_stage = st; s_cfg_data = d;
      step();
      s_cfg_we = 0;
   endtask

   task automatic send_req(input int id, input int len);
      bit acc;
      acc = 0;
      s_req_valid = 1; s_req_id = id; s_req_len = len;
      for (int i = 0; i < 400 && !acc; i++) begin
         acc = m_req_ready(cyc);
         step();
      end
      s_req_valid = 0;
      if (!acc) check_val("req_accept_timeout", 144'(0), 144'(1));
   endtask

   task automatic fill_tables();
      for (int id = 0; id < 4; id++)
         for (int s = 0; s < NST; s++) cfg_write(id, s, 16'($urandom));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      s_cfg_data = '0;
      for (int i = 0; i < 3; i++) step();
      s_rst = 0;

      for (int s = 0; s < NST; s++) cfg_write(1, s, 16'hA5A5 + 16'(s));
      cfg_write(1, 12, 16'hFFFF);
      send_req(1, 1);
      idle(25);
      for (int s = 0; s < NST; s++)
         check_val("a5_stage", 144'(switch_set[s]), 144'(16'hA5A5 + 16'(s)));

      for (int s = 0; s < NST; s++) begin
         cfg_write(0, s, 16'($urandom));
         cfg_write(2, s, 16'($urandom));
         cfg_write(3, s, 16'($urandom));
      end
      send_req(0, 3);
      send_req(2, 2);
      idle(25);

      send_req(1, 4);
      cfg_write(1, 3, 16'h1234);
      idle(25);
      send_req(1, 1);
      idle(25);
      check_val("cfg_rejected", 144'(switch_set[3]), 144'(16'hA5A8));
      cfg_write(1, 3, 16'h1234);
      send_req(1, 1);
      idle(25);
      check_val("cfg_applied", 144'(switch_set[3]), 144'(16'h1234));

      send_req(2, 0);
      idle(5);

      send_req(3, 4);
      idle(4);
      s_rst = 1;
      step();
      idle(30);

      fill_tables();
      send_req(1, 2);
      idle(70);
      send_req(3, 255);
      idle(20);

      for (int i = 0; i < 2000; i++) begin
         s_rst       = ($urandom_range(0, 399) == 0);
         s_req_valid = ($urandom_range(0, 2) == 0);
         s_req_id    = int'($urandom_range(0, 3));
         s_req_len   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40))
                                                   : int'($urandom_range(0, 5));
         s_cfg_we    = !s_req_valid && ($urandom_range(0, 3) == 0);
         s_cfg_id    = int'($urandom_range(0, 3));
         s_cfg_stage = int'($urandom_range(0, 10));
         s_cfg_data  = 16'($urandom);
         step();
      end
      idle(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/benes_perm_scheduler.md
Name: benes_perm_scheduler

Overview:
- Controller for the pipelined Benes permutation network (STAGE_NUM registered switch stages, SWITCH_NUM 2x2 switches per stage).
- Holds a table of NUM_CFG permutation configurations and accepts burst requests (config id plus beat count).
- Drives each stage's switch_set skewed in time, so every beat sees its own configuration at each stage. Back-to-back bursts with different permutations therefore need no drain.
- Generates the network input strobe and tracks output valid/last.

Parameters:
- SWITCH_NUM, 16, switches per stage (network SIZE = 2*SWITCH_NUM)
- STAGE_NUM, 9, switch stages (2*log2(SIZE)-1)
- STAGE_LAT, 2, cycles between a beat sampling stage s and stage s+1
- OUT_LAT, 17, cycles from net_in_valid to the beat on o_port ((STAGE_NUM-1)*STAGE_LAT+1)
- NUM_CFG, 4, stored permutations; power of two
- CFG_W, 2, log2(NUM_CFG)
- LEN_W, 8, burst length width

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- cfg_we, input, 1, config word write strobe
- cfg_ready, output, 1, config write accepted (high only when idle and nothing in flight)
- cfg_id, input, CFG_W, permutation slot
- cfg_stage, input, 4, stage index 0..STAGE_NUM-1
- cfg_data, input, SWITCH_NUM, switch bits for (cfg_id, cfg_stage)
- req_valid, input, 1, burst request
- req_ready, output, 1, request accepted when req_valid&req_ready
- req_cfg_id, input, CFG_W, permutation to use
- req_len, input, LEN_W, beats in burst
- net_in_valid, output, 1, i_port beat valid this cycle
- switch_set, output, [SWITCH_NUM-1:0] x STAGE_NUM, per-stage switch control to network
- out_valid, output, 1, o_port beat valid
- out_last, output, 1, final beat of a burst on o_port
- busy, output, 1, burst issuing or any beat in flight

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, except req_ready=1 and cfg_ready=1 from the first cycle after reset. Config table is cleared to 0. FSM goes to IDLE. All in-flight tags are cleared, so out_valid stays 0 even if beats were mid-network.
- Config write: when cfg_we&cfg_ready, table[cfg_id][cfg_stage] <= cfg_data. cfg_stage >= STAGE_NUM is ignored. cfg_we while cfg_ready=0 is dropped, not queued. cfg_ready = (state==IDLE) & ~busy.
- FSM IDLE:
  - req_ready=1.
  - Accept with req_len!=0 -> ISSUE: cur_id=req_cfg_id, remaining=req_len.
  - Accept with req_len==0 -> consumed, no beats, stay IDLE.
- FSM ISSUE:
  - net_in_valid=1 every cycle; remaining decrements.
  - On the last beat (remaining==1), req_ready=1. If a request is accepted that cycle, the next burst issues from the following cycle with zero bubble; otherwise -> IDLE.
  - req_ready=0 on non-last ISSUE cycles.
  - No backpressure: the network is free-running.
- Stage tags:
  - A beat issued at cycle T carries (valid, id, last) through a tag pipeline.
  - Stage s holds the tag during cycle T+s*STAGE_LAT. switch_set[s] = table[id][s] during exactly that cycle (registered, no combinational path from req inputs).
  - When stage s has no valid tag, switch_set[s] holds its last value.
- Output: out_valid/out_last assert in cycle T+OUT_LAT for each beat issued at T. out_last marks the final beat of each burst.
- busy = (state==ISSUE) | any tag valid. It drops the cycle after the last beat's out_valid.
- Simultaneous events: a request accepted on the last ISSUE beat gives a continuous net_in_valid. cfg_we during ISSUE or drain is rejected. Reset overrides everything.
- remaining is LEN_W bits; max burst = 2^LEN_W-1 beats, with no wrap.

Test Plan:
- Reset, write id1 stage0..8 with 16'hA5A5+stage, req(id1, len 1) at T -> net_in_valid at T; switch_set[s]=16'hA5A5+s during cycle T+2s; out_valid and out_last at T+17; busy drops at T+18.
- Req(id0, len 3), then req(id2, len 2) held valid -> id2 accepted on the 3rd beat; net_in_valid high 5 consecutive cycles. Stage 4 shows id0 config for 3 cycles, then id2 config for 2 cycles. out_last on output beats 3 and 5.
- cfg_we during a burst -> cfg_ready=0, table unchanged (readback via a later 1-beat burst shows the old value). The same write after busy falls is applied.
- Req with len 0 -> req_ready stays 1; no net_in_valid, no out_valid, busy stays 0.
- Req(id3, len 4); rst at T+5 -> next cycle all outputs 0, req_ready=1, no out_valid ever appears for the aborted beats, switch_set all 0.
- Idle gap after a burst -> switch_set[s] holds the last used config unchanged for 50 cycles.
